// File: rtl/fg_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fg_cfg_pkg
// Shared definitions for the function generator configuration sequencer.
// It holds the register address map, the register widths, the sequencer
// state encoding and the packed layout of one full parameter set.
// It also holds a helper that applies one host write to a parameter set.
// No ports (package).
// -----------------------------------------------------------------------------
package fg_cfg_pkg;

   localparam int CTRL_W = 8;
   localparam int REG_W  = 16;
   localparam int ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_CONTROL   = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_PRESCALER = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_COMPARE   = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_COMMIT    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_APPLY = 2'd2
   } cfg_state_t;

   typedef struct packed {
      logic [CTRL_W-1:0] control;
      logic [REG_W-1:0]  prescaler;
      logic [REG_W-1:0]  compare;
   } cfg_regs_t;

   // Returns the parameter set with one host write merged in. A COMMIT
   // address carries no data, so the set comes back untouched.
   function automatic cfg_regs_t write_shadow(input cfg_regs_t cur,
                                              input logic [ADDR_W-1:0] addr,
                                              input logic [REG_W-1:0] data);
      cfg_regs_t upd;
      upd = cur;
      case (addr)
         ADDR_CONTROL:   upd.control   = data[CTRL_W-1:0];
         ADDR_PRESCALER: upd.prescaler = data;
         ADDR_COMPARE:   upd.compare   = data;
         default:        upd = cur;
      endcase
      return upd;
   endfunction

endpackage

// File: rtl/fg_cfg_if.sv
// -----------------------------------------------------------------------------
// fg_cfg_if
// Host register write channel into the configuration sequencer.
// A write transfers on a clock edge where wr_valid and wr_ready are both high.
//   wr_valid  host -> ctrl   write request
//   wr_ready  ctrl -> host   sequencer can accept a write
//   wr_addr   host -> ctrl   0=CONTROL 1=PRESCALER 2=COMPARE 3=COMMIT
//   wr_data   host -> ctrl   write data; CONTROL uses bits [7:0]
// Modports: master (host side), slave (sequencer side).
// -----------------------------------------------------------------------------
interface fg_cfg_if;
   import fg_cfg_pkg::*;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [REG_W-1:0]  wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/fg_timebase.sv
// -----------------------------------------------------------------------------
// fg_timebase
// Prescaled tick generator and phase counter for the function generator.
// The prescale count runs 0..prescaler. tick is high for the one cycle in
// which the count sits at the prescaler value. phase advances by one at the
// end of every tick cycle and wraps from its maximum value to 0.
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   enable          in   generator enable in effect this cycle
//   enable_next     in   generator enable that will be in effect next cycle
//   prescaler_next  in   prescaler value that will be in effect next cycle
//   clear           in   restart the count and the phase from 0 next cycle
//   tick            out  registered one-cycle strobe
//   phase           out  registered phase count
//   boundary        out  tick while phase is at its maximum (wrap cycle)
// -----------------------------------------------------------------------------
module fg_timebase #(
   parameter int PHASE_W = 8,
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               enable_next,
   input  logic [PRESC_W-1:0] prescaler_next,
   input  logic               clear,
   output logic               tick,
   output logic [PHASE_W-1:0] phase,
   output logic               boundary
);

   logic [PRESC_W-1:0] pcnt;
   logic [PRESC_W-1:0] pcnt_next;
   logic [PHASE_W-1:0] phase_next;

   // Next count and phase. The count restarts after each tick. A disabled
   // generator or a clear holds both at zero. tick already marks the
   // terminal count, so the prescaler for the current cycle is not needed.
   always_comb begin
      pcnt_next  = '0;
      phase_next = '0;
      if (!clear && enable) begin
         if (tick) begin
            pcnt_next  = '0;
            phase_next = phase + 1'b1;
         end else begin
            pcnt_next  = pcnt + 1'b1;
            phase_next = phase;
         end
      end
   end

   // tick is computed one cycle ahead from the next count and the next
   // parameters. This keeps it a flop output while it still lines up with
   // the cycle in which the count equals the prescaler. A prescaler change
   // always comes with a clear, so the next values are known here.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt  <= '0;
         phase <= '0;
         tick  <= 1'b0;
      end else begin
         pcnt  <= pcnt_next;
         phase <= phase_next;
         tick  <= enable_next && (pcnt_next == prescaler_next);
      end
   end

   assign boundary = tick && (phase == {PHASE_W{1'b1}});

endmodule

// File: rtl/fg_config_ctrl.sv
// -----------------------------------------------------------------------------
// fg_config_ctrl
// Configuration sequencer for function_generater. The host writes CONTROL,
// PRESCALER and COMPARE into shadow registers. A COMMIT write arms the
// sequencer. The active outputs then take the whole shadow set in one cycle,
// right after the next phase wrap, so the generator never sees a torn set.
// A disabled generator commits at once. The block also owns the generator
// timebase (fg_timebase).
// Optional feature: define FG_CFG_TIMEOUT_EN to add a forced commit after
// TIMEOUT_CYC armed cycles with no phase wrap.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   bus            if   host write channel (fg_cfg_if.slave)
//   fg_control     out  active CONTROL, bit0 = generator enable
//   fg_prescaler   out  active PRESCALER
//   fg_compare     out  active COMPARE
//   tick           out  one-cycle strobe every fg_prescaler+1 cycles
//   phase          out  phase count, advances on tick
//   busy           out  commit pending
//   commit_done    out  pulse on the cycle the active registers update
//   commit_forced  out  pulse when that update was forced by the timeout
// -----------------------------------------------------------------------------
module fg_config_ctrl
   import fg_cfg_pkg::*;
#(
   parameter int               PHASE_W     = 8,
   parameter logic [CTRL_W-1:0] RST_CONTROL = 8'h00,
   parameter logic [REG_W-1:0]  RST_PRESC   = 16'h0,
   parameter logic [REG_W-1:0]  RST_COMPARE = 16'h0,
   parameter int               TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   fg_cfg_if.slave            bus,
   output logic [CTRL_W-1:0]  fg_control,
   output logic [REG_W-1:0]   fg_prescaler,
   output logic [REG_W-1:0]   fg_compare,
   output logic               tick,
   output logic [PHASE_W-1:0] phase,
   output logic               busy,
   output logic               commit_done,
   output logic               commit_forced
);

   localparam cfg_regs_t RST_REGS = '{control:   RST_CONTROL,
                                      prescaler: RST_PRESC,
                                      compare:   RST_COMPARE};

   cfg_state_t       state;
   cfg_regs_t        shadow;
   cfg_regs_t        active;
   logic             ready_q;
   logic             boundary;
   logic             applying;
   logic             enable_next;
   logic [REG_W-1:0] presc_next;

`ifdef FG_CFG_TIMEOUT_EN
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] wait_cnt;
   logic        forced_pend;
`endif

   assign applying = (state == ST_APPLY);

   // The timebase needs the parameters of the coming cycle. They differ from
   // the current ones only on the cycle the shadow set is applied.
   always_comb begin
      enable_next = active.control[0];
      presc_next  = active.prescaler;
      if (applying) begin
         enable_next = shadow.control[0];
         presc_next  = shadow.prescaler;
      end
   end

   fg_timebase #(
      .PHASE_W (PHASE_W),
      .PRESC_W (REG_W)
   ) u_timebase (
      .clk            (clk),
      .rst            (rst),
      .enable         (active.control[0]),
      .enable_next    (enable_next),
      .prescaler_next (presc_next),
      .clear          (applying),
      .tick           (tick),
      .phase          (phase),
      .boundary       (boundary)
   );

   // Commit sequencer. IDLE takes shadow writes and a COMMIT request. ARMED
   // waits for a phase wrap, or moves on at once when the generator is off.
   // APPLY copies the shadow set to the actives and pulses commit_done.
   // busy and the ready flag are set here from the next state, so they are
   // flops that always agree with the state. A reset drops a pending commit
   // and returns the shadows to their reset values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         shadow      <= RST_REGS;
         active      <= RST_REGS;
         ready_q     <= 1'b1;
         busy        <= 1'b0;
         commit_done <= 1'b0;
`ifdef FG_CFG_TIMEOUT_EN
         commit_forced <= 1'b0;
         wait_cnt      <= '0;
         forced_pend   <= 1'b0;
`endif
      end else begin
         commit_done <= 1'b0;
`ifdef FG_CFG_TIMEOUT_EN
         commit_forced <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (bus.wr_valid && ready_q) begin
                  if (bus.wr_addr == ADDR_COMMIT) begin
                     state   <= ST_ARMED;
                     ready_q <= 1'b0;
                     busy    <= 1'b1;
`ifdef FG_CFG_TIMEOUT_EN
                     wait_cnt <= '0;
`endif
                  end else begin
                     shadow <= write_shadow(shadow, bus.wr_addr, bus.wr_data);
                  end
               end
            end
            ST_ARMED: begin
`ifdef FG_CFG_TIMEOUT_EN
               wait_cnt <= wait_cnt + 16'd1;
`endif
               if (boundary || !active.control[0]) begin
                  state <= ST_APPLY;
`ifdef FG_CFG_TIMEOUT_EN
                  forced_pend <= 1'b0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state       <= ST_APPLY;
                  forced_pend <= 1'b1;
`endif
               end
            end
            ST_APPLY: begin
               active      <= shadow;
               commit_done <= 1'b1;
               state       <= ST_IDLE;
               ready_q     <= 1'b1;
               busy        <= 1'b0;
`ifdef FG_CFG_TIMEOUT_EN
               commit_forced <= forced_pend;
`endif
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifndef FG_CFG_TIMEOUT_EN
   // Without the timeout feature a commit is never forced.
   assign commit_forced = 1'b0;

   // The timeout length has no effect in this build. A zero length would be
   // meaningless in the timeout build, so this empty guard marks it.
   if (TIMEOUT_CYC < 1) begin : g_no_timeout_len
   end
`endif

   // wr_ready drops at once while reset is held. After that it follows IDLE.
   assign bus.wr_ready = ready_q & ~rst;

   assign fg_control   = active.control;
   assign fg_prescaler = active.prescaler;
   assign fg_compare   = active.compare;

endmodule

// File: tb/tb_fg_config_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fg_config_ctrl
// Self-checking bench for fg_config_ctrl. A behavioural model tracks the
// shadow and active parameter sets and a pending-commit flag. It derives the
// timebase arithmetically from the cycles elapsed since the last restart.
// Every cycle the DUT outputs are compared against this model. Directed
// scenarios add literal expectations, followed by a randomized write/reset
// phase.
// -----------------------------------------------------------------------------
module tb_fg_config_ctrl;
   import fg_cfg_pkg::*;

   localparam int PHASE_W  = 8;
   localparam int TIMEOUT  = 16;
   localparam int PHASE_MOD = 1 << PHASE_W;
`ifdef FG_CFG_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic [7:0]         fg_control;
   logic [15:0]        fg_prescaler;
   logic [15:0]        fg_compare;
   logic               tick;
   logic [PHASE_W-1:0] phase;
   logic               busy;
   logic               commit_done;
   logic               commit_forced;

   int n_checks = 0;
   int n_fails  = 0;

   fg_cfg_if bus ();

   fg_config_ctrl #(
      .PHASE_W     (PHASE_W),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .fg_control    (fg_control),
      .fg_prescaler  (fg_prescaler),
      .fg_compare    (fg_compare),
      .tick          (tick),
      .phase         (phase),
      .busy          (busy),
      .commit_done   (commit_done),
      .commit_forced (commit_forced)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends on its own
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_sh_ctrl, m_act_ctrl;
   logic [15:0] m_sh_p, m_sh_c, m_act_p, m_act_c;
   int          m_run;
   int          m_waited;
   bit          m_pending, m_applying, m_force, m_done, m_forced;

   function automatic bit mTick();
      if (!m_act_ctrl[0]) return 1'b0;
      return (m_run % (int'(m_act_p) + 1)) == int'(m_act_p);
   endfunction

   function automatic int mPhase();
      if (!m_act_ctrl[0]) return 0;
      return (m_run / (int'(m_act_p) + 1)) % PHASE_MOD;
   endfunction

   always @(posedge clk) begin
      bit bnd;
      if (rst) begin
         m_sh_ctrl = 8'h00; m_sh_p = 16'h0; m_sh_c = 16'h0;
         m_act_ctrl = 8'h00; m_act_p = 16'h0; m_act_c = 16'h0;
         m_run = 0; m_waited = 0;
         m_pending = 0; m_applying = 0; m_force = 0; m_done = 0; m_forced = 0;
      end else if (m_applying) begin
         m_act_ctrl = m_sh_ctrl; m_act_p = m_sh_p; m_act_c = m_sh_c;
         m_done = 1; m_forced = m_force;
         m_applying = 0; m_run = 0;
      end else begin
         bnd = mTick() && (mPhase() == PHASE_MOD - 1);
         m_done = 0; m_forced = 0;
         if (m_act_ctrl[0]) m_run++; else m_run = 0;
         if (m_pending) begin
            m_waited++;
            if (bnd || !m_act_ctrl[0]) begin
               m_pending = 0; m_applying = 1; m_force = 0;
            end else if (TO_EN && m_waited == TIMEOUT) begin
               m_pending = 0; m_applying = 1; m_force = 1;
            end
         end else if (bus.wr_valid) begin
            case (bus.wr_addr)
               ADDR_CONTROL:   m_sh_ctrl = bus.wr_data[7:0];
               ADDR_PRESCALER: m_sh_p = bus.wr_data;
               ADDR_COMPARE:   m_sh_c = bus.wr_data;
               default: begin m_pending = 1; m_waited = 0; end
            endcase
         end
      end
   end

   // Compare every output against the model shortly after each edge
   always begin
      @(posedge clk);
      #1;
      checkOutput("fg_control",    fg_control,    m_act_ctrl);
      checkOutput("fg_prescaler",  fg_prescaler,  m_act_p);
      checkOutput("fg_compare",    fg_compare,    m_act_c);
      checkOutput("tick",          tick,          mTick());
      checkOutput("phase",         phase,         mPhase());
      checkOutput("busy",          busy,          m_pending || m_applying);
      checkOutput("commit_done",   commit_done,   m_done);
      checkOutput("commit_forced", commit_forced, m_forced);
      checkOutput("wr_ready",      bus.wr_ready,  !rst && !m_pending && !m_applying);
   end

   // ---------------- stimulus ----------------
   // One host write: wait until the sequencer is ready, then hold the
   // request for exactly one edge. Returns at the negedge after acceptance.
   task automatic applyStimulus(input logic [1:0] a, input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      while (!bus.wr_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.wr_ready) checkOutput("write_wait_timeout", 32'(n), 32'd0);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic waitDone(input int limit, output int n, output int busy_cnt,
                           output logic forced);
      n = 0;
      busy_cnt = 0;
      while (!commit_done && n < limit) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      forced = commit_forced;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n, bc, k, seen;
      logic f;
      rst = 1'b1;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;

      // Reset held for two cycles
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_wr_ready", bus.wr_ready, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_tick", tick, 1'b0);
      checkOutput("rst_prescaler", fg_prescaler, 16'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_wr_ready", bus.wr_ready, 1'b1);

      // Enable with prescaler 3 while disabled: fast commit
      applyStimulus(ADDR_CONTROL, 16'h0001);
      applyStimulus(ADDR_PRESCALER, 16'd3);
      applyStimulus(ADDR_COMMIT, 16'h0);
      waitDone(50, n, bc, f);
      checkOutput("commit_lat_disabled", 32'(n), 32'd2);
      checkOutput("fg_control_on", fg_control, 8'h01);

      // Tick period with prescaler 3
      k = 0;
      while (!tick && k < 10) begin @(negedge clk); k++; end
      @(negedge clk);
      n = 1;
      while (!tick && n < 20) begin @(negedge clk); n++; end
      checkOutput("tick_period", 32'(n), 32'd4);

      // Commit while enabled waits for the phase wrap
      applyStimulus(ADDR_PRESCALER, 16'd7);
      applyStimulus(ADDR_COMPARE, 16'h1234);
      applyStimulus(ADDR_COMMIT, 16'h0);
      checkOutput("armed_prescaler_held", fg_prescaler, 16'd3);
      checkOutput("armed_wr_ready", bus.wr_ready, 1'b0);
      k = 0;
      while (!(tick && phase == 8'd255) && k < 1100) begin @(negedge clk); k++; end
      checkOutput("boundary_found", tick && phase == 8'd255, 1'b1);
      @(negedge clk);
      checkOutput("phase_wrapped", phase, 8'd0);
      checkOutput("done_not_yet", commit_done, 1'b0);
      checkOutput("prescaler_pre_apply", fg_prescaler, 16'd3);
      @(negedge clk);
      checkOutput("done_wrap_plus1", commit_done, 1'b1);
      checkOutput("new_prescaler", fg_prescaler, 16'd7);
      checkOutput("new_compare", fg_compare, 16'h1234);
      checkOutput("phase_restart", phase, 8'd0);

      // Disable, then a commit with the generator off takes 2 cycles
      applyStimulus(ADDR_CONTROL, 16'h0000);
      applyStimulus(ADDR_COMMIT, 16'h0);
      waitDone(2500, n, bc, f);
      checkOutput("disable_commit_seen", commit_done, 1'b1);
      applyStimulus(ADDR_COMMIT, 16'h0);
      waitDone(50, n, bc, f);
      checkOutput("commit_lat_off", 32'(n), 32'd2);
      checkOutput("busy_cycles_off", 32'(bc), 32'd2);

      // Reset while ARMED discards the commit and the shadows
      applyStimulus(ADDR_CONTROL, 16'h0001);
      applyStimulus(ADDR_PRESCALER, 16'd3);
      applyStimulus(ADDR_COMMIT, 16'h0);
      waitDone(50, n, bc, f);
      applyStimulus(ADDR_COMPARE, 16'hBEEF);
      applyStimulus(ADDR_PRESCALER, 16'd5);
      applyStimulus(ADDR_COMMIT, 16'h0);
      pulseReset();
      checkOutput("rst_armed_busy", busy, 1'b0);
      checkOutput("rst_armed_compare", fg_compare, 16'h0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (commit_done) seen++;
      end
      checkOutput("rst_armed_no_done", 32'(seen), 32'd0);
      applyStimulus(ADDR_COMMIT, 16'h0);
      waitDone(50, n, bc, f);
      checkOutput("shadow_reverted_compare", fg_compare, 16'h0);
      checkOutput("shadow_reverted_presc", fg_prescaler, 16'h0);

      // Timeout behaviour with a very slow timebase
      applyStimulus(ADDR_CONTROL, 16'h0001);
      applyStimulus(ADDR_PRESCALER, 16'hFFFF);
      applyStimulus(ADDR_COMMIT, 16'h0);
      waitDone(50, n, bc, f);
      applyStimulus(ADDR_COMPARE, 16'h00AA);
      applyStimulus(ADDR_COMMIT, 16'h0);
      if (TO_EN) begin
         waitDone(100, n, bc, f);
         checkOutput("forced_latency", 32'(n), 32'd17);
         checkOutput("forced_flag", f, 1'b1);
         checkOutput("forced_compare", fg_compare, 16'h00AA);
      end else begin
         waitDone(40, n, bc, f);
         checkOutput("no_timeout_wait", 32'(n), 32'd40);
         checkOutput("no_timeout_busy", busy, 1'b1);
         checkOutput("no_timeout_compare", fg_compare, 16'h0);
      end
      pulseReset();

      // Randomized writes, commits and occasional resets
      for (int i = 0; i < 200; i++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 5) begin
            pulseReset();
         end else if (sel < 30) begin
            applyStimulus(ADDR_CONTROL, 16'($urandom_range(0, 255)));
         end else if (sel < 50) begin
            applyStimulus(ADDR_PRESCALER, 16'($urandom_range(0, 1)));
         end else if (sel < 75) begin
            applyStimulus(ADDR_COMPARE, 16'($urandom_range(0, 65535)));
         end else begin
            applyStimulus(ADDR_COMMIT, 16'($urandom_range(0, 65535)));
         end
         k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) @(negedge clk);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
